load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Data-side adapter between the core's memory stage and the word-only, 1-cycle-latency bram.
- Accepts byte, half and word loads and stores.
- Sign- or zero-extends loads.
- Implements sub-word stores as read-modify-write, because bram writes whole words only.
- Drives bram's read and write ports directly. It parks the read address at INVALID_ADDRESS when idle, so bram returns 32'hbeefbeef in that state.

Parameters:
MEM_SIZE, 1024, bram depth in 32-bit words; used only by the optional range check.
INVALID_ADDRESS, 32'hfafafafa, idle/park address; must match bram.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
req_unsigned  in  1  zero-extend load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_data  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned, illegal size, or out-of-range (option)
mem_read_addr  out  32  to bram read_addr
mem_read_data  in  32  from bram read_data, valid 1 cycle after its address
mem_write_addr  out  32  to bram write_addr
mem_write_data  out  32  to bram write_data
mem_write_enable  out  1  to bram write_enable

Behaviour:
- Reset is asynchronous, active-low, clock is clk. While rstn = 0:
  - state = IDLE;
  - resp_valid = 0, resp_data = 0, resp_err = 0;
  - req_ready = 0;
  - mem_read_addr = mem_write_addr = INVALID_ADDRESS;
  - mem_write_enable = 0, mem_write_data = 0.
- Reset mid-operation abandons the operation. An in-flight RMW performs no write.
- States: IDLE, LOAD_WAIT, RMW_WR. req_ready = 1 only in IDLE (out of reset).
- Memory outputs are combinational from the state, captured registers and the accepted request. resp_* are registered.
- Aligned address A = {addr[31:2], 2'b00}. A never equals INVALID_ADDRESS, whose low bits are 2'b10.
- Error check on accept:
  - errors are size = 3, half with addr[0] = 1, and word with addr[1:0] != 0;
  - no memory access is made;
  - next cycle: resp_valid = 1, resp_err = 1, resp_data = 0;
  - state stays IDLE.
- Load accept (IDLE):
  - mem_read_addr = A;
  - capture addr[1:0], size and unsigned;
  - go to LOAD_WAIT.
- LOAD_WAIT:
  - extract the lane from mem_read_data (little-endian);
  - extend to 32 bits;
  - register the result into resp_data with resp_valid = 1;
  - go to IDLE.
  - Load latency is 2 cycles, accept to resp_valid.
- Word store accept (IDLE):
  - same cycle: mem_write_enable = 1, mem_write_addr = A, mem_write_data = req_wdata;
  - resp_valid next cycle;
  - state stays IDLE, so back-to-back accepts are allowed.
- Sub-word store accept (IDLE):
  - mem_read_addr = A;
  - capture wdata, lane and size;
  - go to RMW_WR.
- RMW_WR:
  - merge the captured bytes into mem_read_data at their lanes;
  - drive the write to A;
  - resp_valid next cycle;
  - go to IDLE.
  - Sub-word store latency is 2 cycles; req_ready is low for 1 cycle.
- In all other cycles: mem_read_addr = INVALID_ADDRESS and mem_write_enable = 0.
- Write-then-read ordering:
  - a word store at cycle n followed by a load of the same word accepted at n+1 returns the new data;
  - bram commits the write at the end of cycle n, and the read samples at the end of cycle n+1.
- resp_valid is a pulse with no backpressure. The consumer must take it.

Optional Feature:
LSU_RANGE_CHECK_EN
- Defined: any request with addr[31:2] >= MEM_SIZE completes like a misalignment error: resp_err = 1, no bram access.
- Undefined: no range check; the address aliases modulo MEM_SIZE words inside bram.

Decomposition:
- Package lsu_pkg:
  - size enum (SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2);
  - state enum (IDLE, LOAD_WAIT, RMW_WR);
  - INVALID_ADDRESS default constant.
- Sub-module lsu_lane_align, purely combinational:
  - load extract/extend;
  - store merge from lane, size and old word.
- The FSM and handshakes stay in load_store_unit.

Test Plan:
- Preload word 0x10 = 32'h8899AABB; lb at 0x11 -> resp_data 32'hFFFFFFAA, 2 cycles after accept. lbu at 0x11 -> 32'h000000AA.
- lh at 0x12 -> 32'hFFFF8899. lhu at 0x12 -> 32'h00008899. lh at 0x13 -> resp_err = 1, no mem_read_addr change from INVALID_ADDRESS.
- sb 0x13 with wdata 0x12 on preloaded 32'h8899AABB:
  - req_ready is low for 1 cycle;
  - write of 32'h1299AABB to 0x10;
  - a following lw at 0x10 returns 32'h1299AABB.
- sw 0x20 = 32'hCAFEF00D at cycle n, then lw 0x20 accepted at n+1 -> 32'hCAFEF00D; resp_valid at n+1 and n+3.
- Assert rstn low during RMW_WR -> mem_write_enable is never 1, resp_valid = 0, and word 0x10 is unchanged.
- Idle for 10 cycles -> mem_read_addr = 32'hfafafafa and mem_write_enable = 0 throughout. With LSU_RANGE_CHECK_EN defined, lw at 4*MEM_SIZE -> resp_err = 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// the bram park address and the alignment rule.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        RMW_WR
    } state_e;

    localparam logic [31:0] INVALID_ADDRESS_DEF = 32'hfafafafa;

    // Size 3 is illegal and always reported as an error.
    function automatic logic bad_align(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            SZ_W:    return |lo;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: little-endian load extract/extend and sub-word store
// merge into the old bram word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;

    assign sh = {lane, 3'b000};

    always_comb begin
        shifted   = old_word >> sh;
        load_data = shifted;
        mask      = 32'hffffffff;
        case (size)
            SZ_B: begin
                load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
                mask      = 32'h000000ff << sh;
            end
            SZ_H: begin
                load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
                mask      = 32'h0000ffff << sh;
            end
            default: ;
        endcase
        merged = (old_word & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-side adapter between the memory stage and a word-only, 1-cycle bram.
// Optional LSU_RANGE_CHECK_EN: reject addresses beyond MEM_SIZE words.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int          MEM_SIZE        = 1024,
    parameter logic [31:0] INVALID_ADDRESS = INVALID_ADDRESS_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable
);

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    state_e      state;
    logic        live;
    logic [29:0] cap_word;
    logic [1:0]  cap_lane;
    logic [1:0]  cap_size;
    logic        cap_uns;
    logic [31:0] cap_wdata;

    logic        accept, out_of_range, err;
    logic        load, word_store, sub_store;
    logic [31:0] aligned, load_data, merged;

    // live keeps req_ready low until the first clock after reset release.
    assign req_ready    = live && (state == IDLE);
    assign accept       = req_valid && req_ready;
    assign aligned      = {req_addr[31:2], 2'b00};
    assign out_of_range = RANGE_CHECK && ({2'b00, req_addr[31:2]} >= 32'(MEM_SIZE));
    assign err          = bad_align(req_size, req_addr[1:0]) || out_of_range;
    assign load         = accept && !err && !req_we;
    assign word_store   = accept && !err && req_we && (req_size == SZ_W);
    assign sub_store    = accept && !err && req_we && (req_size != SZ_W);

    lsu_lane_align u_align (
        .lane       (cap_lane),
        .size       (cap_size),
        .is_unsigned(cap_uns),
        .old_word   (mem_read_data),
        .wdata      (cap_wdata),
        .load_data  (load_data),
        .merged     (merged)
    );

    always_comb begin
        mem_read_addr    = (load || sub_store) ? aligned : INVALID_ADDRESS;
        mem_write_enable = 1'b0;
        mem_write_addr   = INVALID_ADDRESS;
        mem_write_data   = 32'h0;
        if (state == RMW_WR) begin
            mem_write_enable = 1'b1;
            mem_write_addr   = {cap_word, 2'b00};
            mem_write_data   = merged;
        end else if (word_store) begin
            mem_write_enable = 1'b1;
            mem_write_addr   = aligned;
            mem_write_data   = req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            live       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_err   <= 1'b0;
            cap_word   <= '0;
            cap_lane   <= '0;
            cap_size   <= '0;
            cap_uns    <= 1'b0;
            cap_wdata  <= '0;
        end else begin
            live       <= 1'b1;
            resp_valid <= (accept && err) || word_store || (state != IDLE);
            resp_err   <= accept && err;
            resp_data  <= (state == LOAD_WAIT) ? load_data : 32'h0;
            case (state)
                IDLE: begin
                    if (load)           state <= LOAD_WAIT;
                    else if (sub_store) state <= RMW_WR;
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                cap_word  <= req_addr[31:2];
                cap_lane  <= req_addr[1:0];
                cap_size  <= req_size;
                cap_uns   <= req_unsigned;
                cap_wdata <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: bram model, byte-level reference memory,
// directed plan items plus a randomized access mix.
module tb_load_store_unit;

    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] INV       = 32'hfafafafa;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [31:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;
    logic        mem_write_enable;

    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    logic [31:0] bram    [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MEM_SIZE(MEM_WORDS), .INVALID_ADDRESS(INV)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable)
    );

    always #5 clk = ~clk;

    // Word-only bram, 1-cycle read latency, parks at beefbeef on the invalid address.
    always @(posedge clk) begin
        if (pre_we) bram[pre_idx] <= pre_data;
        else if (mem_write_enable) bram[mem_write_addr[11:2]] <= mem_write_data;
        mem_read_data <= (mem_read_addr == INV) ? 32'hbeefbeef : bram[mem_read_addr[11:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-by-byte view of memory, updating ref_mem for stores.
    function automatic void model(input bit we, input logic [1:0] sz, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] d, output logic [31:0] nw,
                                  output bit e, output int lat);
        int idx, lo, n;
        logic [31:0] w, v;
        lo  = int'(addr % 4);
        idx = int'((addr / 4) % MEM_WORDS);
        n   = 1 << sz;
        e   = (sz == 2'd3) || (lo % n != 0);
`ifdef LSU_RANGE_CHECK_EN
        if (addr / 4 >= MEM_WORDS) e = 1'b1;
`endif
        d   = 32'h0;
        nw  = ref_mem[idx];
        lat = 1;
        if (e) return;
        w = ref_mem[idx];
        if (we) begin
            for (int b = 0; b < n; b++) w[8*(lo+b) +: 8] = wd[8*b +: 8];
            ref_mem[idx] = w;
            nw  = w;
            lat = (n == 4) ? 1 : 2;
        end else begin
            v = 32'h0;
            for (int b = 0; b < n; b++) v[8*b +: 8] = w[8*(lo+b) +: 8];
            if (!uns && v[8*n-1]) for (int b = n; b < 4; b++) v[8*b +: 8] = 8'hff;
            d   = v;
            lat = 2;
        end
    endfunction

    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input string tag);
        logic [31:0] ed, ew, a;
        bit ee;
        int el, lat, g;
        a = {addr[31:2], 2'b00};
        model(we, sz, uns, addr, wd, ed, ew, ee, el);
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 20) begin @(negedge clk); g++; end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        #1;
        if (ee) begin
            check({tag, " err rd_addr"}, mem_read_addr, INV);
            check({tag, " err we"}, 32'(mem_write_enable), 32'd0);
        end else if (we && sz == 2'd2) begin
            check({tag, " sw we"}, 32'(mem_write_enable), 32'd1);
            check({tag, " sw waddr"}, mem_write_addr, a);
            check({tag, " sw wdata"}, mem_write_data, wd);
        end else begin
            check({tag, " rd_addr"}, mem_read_addr, a);
            check({tag, " we"}, 32'(mem_write_enable), 32'd0);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && we && !ee && sz != 2'd2) begin
                check({tag, " rmw ready"}, 32'(req_ready), 32'd0);
                check({tag, " rmw we"}, 32'(mem_write_enable), 32'd1);
                check({tag, " rmw waddr"}, mem_write_addr, a);
                check({tag, " rmw wdata"}, mem_write_data, ew);
            end
        end while (!resp_valid && lat < 8);
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " data"}, resp_data, ed);
        check({tag, " err"}, 32'(resp_err), 32'(ee));
        @(negedge clk);
        check({tag, " pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] ed, ew, ed2, r;
        bit ee;
        int el;

        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        pre_we = 1'b0; pre_idx = '0; pre_data = '0;

        // Preload words 0..127 during reset; reference starts identical.
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            r = $urandom;
            pre_we = 1'b1; pre_idx = 10'(i); pre_data = r;
            ref_mem[i] = r;
        end
        @(negedge clk);
        pre_we = 1'b0;
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_data", resp_data, 32'd0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rd_addr", mem_read_addr, INV);
        check("rst wr_addr", mem_write_addr, INV);
        check("rst we", 32'(mem_write_enable), 32'd0);
        check("rst wdata", mem_write_data, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        issue(1, 2'd2, 0, 32'h10, 32'h8899AABB, "sw 0x10");
        issue(0, 2'd0, 0, 32'h11, 32'h0, "lb 0x11");
        issue(0, 2'd0, 1, 32'h11, 32'h0, "lbu 0x11");
        issue(0, 2'd1, 0, 32'h12, 32'h0, "lh 0x12");
        issue(0, 2'd1, 1, 32'h12, 32'h0, "lhu 0x12");
        issue(0, 2'd1, 0, 32'h13, 32'h0, "lh 0x13");
        issue(0, 2'd3, 0, 32'h10, 32'h0, "size3");
        issue(1, 2'd0, 0, 32'h13, 32'h12, "sb 0x13");
        issue(0, 2'd2, 0, 32'h10, 32'h0, "lw 0x10");
        check("rmw result", ref_mem[4], 32'h1299AABB);

        // Word store at n, load of the same word accepted at n+1.
        model(1, 2'd2, 0, 32'h20, 32'hCAFEF00D, ed, ew, ee, el);
        model(0, 2'd2, 0, 32'h20, 32'h0, ed2, ew, ee, el);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_we = 1'b0;
        @(negedge clk);
        check("b2b sw resp n+1", 32'(resp_valid), 32'd1);
        check("b2b lw accepted", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b gap n+2", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("b2b lw resp n+3", 32'(resp_valid), 32'd1);
        check("b2b lw data", resp_data, ed2);

        // Reset while in RMW_WR: the write must never happen.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h11; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0; rstn = 1'b0;
        #1;
        check("rst-rmw we", 32'(mem_write_enable), 32'd0);
        check("rst-rmw ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst-rmw we hold", 32'(mem_write_enable), 32'd0);
            check("rst-rmw resp_valid", 32'(resp_valid), 32'd0);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("rst-rmw bram word", bram[4], ref_mem[4]);
        issue(0, 2'd2, 0, 32'h10, 32'h0, "lw after rst");

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle rd_addr", mem_read_addr, INV);
            check("idle we", 32'(mem_write_enable), 32'd0);
        end

        // Beyond MEM_SIZE: error with the range check, alias to word 0 without.
        issue(0, 2'd2, 0, 32'(4 * MEM_WORDS), 32'h0, "lw range");

        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 511)),
                  $urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
